// File: rtl/datapath_pkg.sv
// Shared constants for the sequential datapath: default sizes and ALU opcodes.
package datapath_pkg;

    localparam int unsigned REG_SIZE_DEFAULT = 32;
    localparam int unsigned NUM_GPR_DEFAULT  = 16;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluShr = 4'd4,
        AluShl = 4'd5,
        AluRor = 4'd6,
        AluRol = 4'd7,
        AluNeg = 4'd8,
        AluNot = 4'd9,
        AluMul = 4'd10,
        AluDiv = 4'd11
    } alu_op_e;

    function automatic logic is_multi_cycle(logic [3:0] op);
        return (op == AluMul) || (op == AluDiv);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiplier / restoring divider, one result bit per cycle.
// finish_o and result_o expose the final step so the owner can capture it on that edge.
module mul_div_unit
    import datapath_pkg::*;
#(
    parameter int unsigned Width = REG_SIZE_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               div_i,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               finish_o,
    output logic [2*Width-1:0] result_o
);

    localparam int unsigned CntW = $clog2(Width);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               div_q;
    logic               done_q;
    logic [Width-1:0]   opd_q;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [Width:0]     mul_sum, rem_w, rem_n;
    logic               last;

    // MUL: acc = {partial, multiplier}, add then shift right.
    // DIV: acc = {remainder, dividend/quotient}, shift left then trial-subtract.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        rem_w   = acc_q[2*Width-1:Width-1];
        rem_n   = rem_w;
        if (div_q) begin
            if (rem_w >= {1'b0, opd_q}) begin
                rem_n = rem_w - {1'b0, opd_q};
            end
            acc_d = {rem_n[Width-1:0], acc_q[Width-2:0], rem_w >= {1'b0, opd_q}};
        end else begin
            acc_d = {mul_sum, acc_q[Width-1:1]};
        end
    end

    assign last     = (state_q == StRun) && (cnt_q == CntW'(Width - 1));
    assign finish_o = last;
    assign result_o = acc_d;
    assign busy_o   = (state_q == StRun);
    assign done_o   = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
            opd_q   <= '0;
            acc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        div_q   <= div_i;
                        opd_q   <= div_i ? b_i : a_i;
                        acc_q   <= {{Width{1'b0}}, div_i ? a_i : b_i};
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/seq_datapath.sv
// Single-bus sequential datapath: GPRs, PC/IR/Y/MAR/HI/LO/MDR, wide Z and an ALU
// with an iterative MUL/DIV unit. Bus contention zeroes the bus and sets a sticky flag.
module seq_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned REG_SIZE = REG_SIZE_DEFAULT,
    parameter int unsigned NUM_GPR  = NUM_GPR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_GPR-1:0]  gpr_in,
    input  logic [NUM_GPR-1:0]  gpr_out,
    input  logic                pc_in,
    input  logic                pc_out,
    input  logic                ir_in,
    input  logic                y_in,
    input  logic                mar_in,
    input  logic                hi_in,
    input  logic                hi_out,
    input  logic                lo_in,
    input  logic                lo_out,
    input  logic                z_in,
    input  logic                z_high_out,
    input  logic                z_low_out,
    input  logic                mdr_in,
    input  logic                mdr_out,
    input  logic                read,
    input  logic [REG_SIZE-1:0] m_data_in,
    input  logic [3:0]          alu_op,
    input  logic                alu_start,
    output logic                alu_busy,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] bus_data,
    output logic [REG_SIZE-1:0] mar_data,
    output logic [REG_SIZE-1:0] ir_data,
    output logic                bus_err
);

    localparam int          NumSrc = NUM_GPR + 6;
    localparam int unsigned ShW    = $clog2(REG_SIZE);

    logic [REG_SIZE-1:0]   gpr_q [NUM_GPR];
    logic [REG_SIZE-1:0]   pc_q, ir_q, y_q, mar_q, hi_q, lo_q, mdr_q;
    logic [2*REG_SIZE-1:0] z_q;
    logic                  bus_err_q;

    logic [NumSrc-1:0]     drv_en;
    logic [REG_SIZE-1:0]   drv_val [NumSrc];
    logic [REG_SIZE-1:0]   bus_or;
    logic                  any_en, bus_multi;

    logic [REG_SIZE-1:0]   alu_res;
    logic [ShW-1:0]        sh, neg_sh;
    alu_op_e               op;

    logic                  md_accept, md_busy, md_done, md_finish;
    logic [2*REG_SIZE-1:0] md_result;

    assign drv_en = {mdr_out, z_low_out, z_high_out, lo_out, hi_out, pc_out, gpr_out};

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            drv_val[i] = gpr_q[i];
        end
        drv_val[NUM_GPR]     = pc_q;
        drv_val[NUM_GPR + 1] = hi_q;
        drv_val[NUM_GPR + 2] = lo_q;
        drv_val[NUM_GPR + 3] = z_q[2*REG_SIZE-1:REG_SIZE];
        drv_val[NUM_GPR + 4] = z_q[REG_SIZE-1:0];
        drv_val[NUM_GPR + 5] = mdr_q;
    end

    always_comb begin
        bus_or    = '0;
        any_en    = 1'b0;
        bus_multi = 1'b0;
        for (int i = 0; i < NumSrc; i++) begin
            bus_multi = bus_multi | (any_en & drv_en[i]);
            any_en    = any_en | drv_en[i];
            bus_or    = bus_or | (drv_val[i] & {REG_SIZE{drv_en[i]}});
        end
        bus_data = bus_multi ? '0 : bus_or;
    end

    // Rotates use (W - sh) mod W, which is simply the two's complement of sh.
    always_comb begin
        op      = alu_op_e'(alu_op);
        sh      = bus_data[ShW-1:0];
        neg_sh  = -sh;
        case (op)
            AluAdd:  alu_res = y_q + bus_data;
            AluSub:  alu_res = y_q - bus_data;
            AluAnd:  alu_res = y_q & bus_data;
            AluOr:   alu_res = y_q | bus_data;
            AluShr:  alu_res = y_q >> sh;
            AluShl:  alu_res = y_q << sh;
            AluRor:  alu_res = (y_q >> sh) | (y_q << neg_sh);
            AluRol:  alu_res = (y_q << sh) | (y_q >> neg_sh);
            AluNeg:  alu_res = '0 - bus_data;
            AluNot:  alu_res = ~bus_data;
            default: alu_res = '0;
        endcase
    end

    assign md_accept = alu_start && !md_busy && is_multi_cycle(alu_op);

    mul_div_unit #(
        .Width (REG_SIZE)
    ) u_mul_div (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .start_i  (md_accept),
        .div_i    (alu_op == AluDiv),
        .a_i      (y_q),
        .b_i      (bus_data),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .finish_o (md_finish),
        .result_o (md_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            mar_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mdr_q     <= '0;
            z_q       <= '0;
            bus_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gpr_in[i]) gpr_q[i] <= bus_data;
            end
            if (pc_in)  pc_q  <= bus_data;
            if (ir_in)  ir_q  <= bus_data;
            if (y_in)   y_q   <= bus_data;
            if (mar_in) mar_q <= bus_data;
            if (hi_in)  hi_q  <= bus_data;
            if (lo_in)  lo_q  <= bus_data;
            if (mdr_in) mdr_q <= read ? m_data_in : bus_data;
            // A finishing MUL/DIV owns Z; z_in is dead while the unit is busy.
            if (md_finish) begin
                z_q <= md_result;
            end else if (z_in && !md_busy && !is_multi_cycle(alu_op)) begin
                z_q <= {{REG_SIZE{1'b0}}, alu_res};
            end
            bus_err_q <= bus_err_q | bus_multi;
        end
    end

    assign alu_busy = md_busy;
    assign alu_done = md_done;
    assign mar_data = mar_q;
    assign ir_data  = ir_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed bus/ALU/MUL/DIV sequences against a behavioural model.
module tb_seq_datapath;

    localparam int W = 32;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] gpr_in, gpr_out;
    logic         pc_in, pc_out, ir_in, y_in, mar_in, hi_in, hi_out, lo_in, lo_out;
    logic         z_in, z_high_out, z_low_out, mdr_in, mdr_out, read;
    logic [W-1:0] m_data_in;
    logic [3:0]   alu_op;
    logic         alu_start;
    logic         alu_busy, alu_done, bus_err;
    logic [W-1:0] bus_data, mar_data, ir_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpr_in     (gpr_in),
        .gpr_out    (gpr_out),
        .pc_in      (pc_in),
        .pc_out     (pc_out),
        .ir_in      (ir_in),
        .y_in       (y_in),
        .mar_in     (mar_in),
        .hi_in      (hi_in),
        .hi_out     (hi_out),
        .lo_in      (lo_in),
        .lo_out     (lo_out),
        .z_in       (z_in),
        .z_high_out (z_high_out),
        .z_low_out  (z_low_out),
        .mdr_in     (mdr_in),
        .mdr_out    (mdr_out),
        .read       (read),
        .m_data_in  (m_data_in),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_busy   (alu_busy),
        .alu_done   (alu_done),
        .bus_data   (bus_data),
        .mar_data   (mar_data),
        .ir_data    (ir_data),
        .bus_err    (bus_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]   m_gpr [N];
    logic [W-1:0]   m_pc, m_ir, m_y, m_mar, m_hi, m_lo, m_mdr;
    logic [2*W-1:0] m_z, m_pend;
    logic           m_err, m_done;
    int             m_left;
    logic [W-1:0]   m_bus, m_alu;
    logic           m_multi;

    always_comb begin
        int n;
        logic [W-1:0] v;
        n = 0;
        v = '0;
        for (int i = 0; i < N; i++) if (gpr_out[i]) begin n++; v = m_gpr[i]; end
        if (pc_out)     begin n++; v = m_pc; end
        if (hi_out)     begin n++; v = m_hi; end
        if (lo_out)     begin n++; v = m_lo; end
        if (z_high_out) begin n++; v = m_z[63:32]; end
        if (z_low_out)  begin n++; v = m_z[31:0]; end
        if (mdr_out)    begin n++; v = m_mdr; end
        m_multi = (n > 1);
        m_bus   = (n == 1) ? v : '0;
    end

    always_comb begin
        int s;
        logic [63:0] t;
        s = int'(m_bus % 32);
        t = '0;
        case (alu_op)
            4'd0: m_alu = m_y + m_bus;
            4'd1: m_alu = m_y - m_bus;
            4'd2: m_alu = m_y & m_bus;
            4'd3: m_alu = m_y | m_bus;
            4'd4: m_alu = m_y >> s;
            4'd5: m_alu = m_y << s;
            4'd6: begin t = {m_y, 32'h0} >> s; m_alu = t[63:32] | t[31:0]; end
            4'd7: begin t = {32'h0, m_y} << s; m_alu = t[63:32] | t[31:0]; end
            4'd8: m_alu = 32'd0 - m_bus;
            4'd9: m_alu = ~m_bus;
            default: m_alu = '0;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m_gpr[i] <= '0;
            m_pc <= '0; m_ir <= '0; m_y <= '0; m_mar <= '0;
            m_hi <= '0; m_lo <= '0; m_mdr <= '0;
            m_z <= '0; m_pend <= '0; m_err <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            for (int i = 0; i < N; i++) if (gpr_in[i]) m_gpr[i] <= m_bus;
            if (pc_in)  m_pc  <= m_bus;
            if (ir_in)  m_ir  <= m_bus;
            if (y_in)   m_y   <= m_bus;
            if (mar_in) m_mar <= m_bus;
            if (hi_in)  m_hi  <= m_bus;
            if (lo_in)  m_lo  <= m_bus;
            if (mdr_in) m_mdr <= read ? m_data_in : m_bus;
            m_err  <= m_err | m_multi;
            m_done <= (m_left == 1);
            if (m_left > 0) m_left <= m_left - 1;
            if (m_left == 1) m_z <= m_pend;
            else if (m_left == 0 && z_in && !(alu_op == 4'd10 || alu_op == 4'd11))
                m_z <= {32'h0, m_alu};
            if (m_left == 0 && alu_start && (alu_op == 4'd10 || alu_op == 4'd11)) begin
                m_left <= 32;
                if (alu_op == 4'd10)  m_pend <= {32'h0, m_y} * {32'h0, m_bus};
                else if (m_bus == 0)  m_pend <= {m_y, 32'hFFFF_FFFF};
                else                  m_pend <= {m_y % m_bus, m_y / m_bus};
            end
        end
    end

    always @(negedge clk) begin
        check("bus_data", bus_data, m_bus);
        check("mar_data", mar_data, m_mar);
        check("ir_data", ir_data, m_ir);
        check("bus_err", bus_err, m_err);
        check("alu_busy", alu_busy, m_left > 0);
        check("alu_done", alu_done, m_done);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        gpr_in = '0; gpr_out = '0;
        pc_in = 0; pc_out = 0; ir_in = 0; y_in = 0; mar_in = 0;
        hi_in = 0; hi_out = 0; lo_in = 0; lo_out = 0;
        z_in = 0; z_high_out = 0; z_low_out = 0;
        mdr_in = 0; mdr_out = 0; read = 0; m_data_in = '0;
        alu_op = '0; alu_start = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_mdr(input logic [W-1:0] v);
        idle(); mdr_in = 1; read = 1; m_data_in = v; tick(); idle();
    endtask

    task automatic load_gpr(input int r, input logic [W-1:0] v);
        put_mdr(v); mdr_out = 1; gpr_in[r] = 1'b1; tick(); idle();
    endtask

    task automatic set_y(input logic [W-1:0] v);
        put_mdr(v); mdr_out = 1; y_in = 1; tick(); idle();
    endtask

    task automatic alu1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        set_y(a); put_mdr(b); mdr_out = 1; alu_op = op; z_in = 1; tick(); idle();
    endtask

    task automatic start_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        set_y(a); put_mdr(b); mdr_out = 1; alu_op = op; alu_start = 1; tick(); idle();
    endtask

    task automatic read_z(output logic [W-1:0] hi, output logic [W-1:0] lo);
        z_high_out = 1; #1 hi = bus_data; tick(); idle();
        z_low_out = 1;  #1 lo = bus_data; tick(); idle();
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < 100 && !alu_done; k++) begin
            if (alu_busy) busy_cycles++;
            tick();
        end
        check("md_done_seen", alu_done, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0] zh, zl;
    int           bc;
    logic [W-1:0] pats [2] = '{32'h0000_0024, 32'h8000_0003};

    initial begin
        idle();
        reset_n = 0;
        tick(3);
        reset_n = 1;
        check("rst_busy", alu_busy, 1'b0);
        check("rst_err", bus_err, 1'b0);
        check("rst_mar", mar_data, 32'h0);

        // R3 <- 5, R7 <- 9, Y <- R3, Z <- Y + R7
        load_gpr(3, 32'd5);
        load_gpr(7, 32'd9);
        gpr_out[3] = 1; y_in = 1; tick(); idle();
        gpr_out[7] = 1; alu_op = 4'd0; z_in = 1; tick(); idle();
        read_z(zh, zl);
        check("add_z_lo", zl, 32'd14);
        check("add_z_hi", zh, 32'd0);

        gpr_out[7] = 1; mar_in = 1; ir_in = 1; tick(); idle();
        check("mar_load", mar_data, 32'd9);
        check("ir_load", ir_data, 32'd9);
        gpr_out[3] = 1; pc_in = 1; hi_in = 1; tick(); idle();
        pc_out = 1; lo_in = 1; tick(); idle();
        lo_out = 1; #1 check("lo_from_pc", bus_data, 32'd5); tick(); idle();

        // Every single-cycle opcode against two operand patterns
        for (int p = 0; p < 2; p++) begin
            for (int op = 0; op < 16; op++) begin
                if (op == 10 || op == 11) continue;
                alu1(4'(op), 32'hF0F0_1234, pats[p]);
                read_z(zh, zl);
            end
        end
        alu1(4'd1, 32'd3, 32'd5);  read_z(zh, zl); check("sub_wrap", zl, 32'hFFFF_FFFE);
        alu1(4'd8, 32'd0, 32'd1);  read_z(zh, zl); check("neg_one", zl, 32'hFFFF_FFFF);
        alu1(4'd6, 32'd1, 32'd1);  read_z(zh, zl); check("ror_one", zl, 32'h8000_0000);
        alu1(4'd7, 32'h8000_0001, 32'd1);  read_z(zh, zl); check("rol_one", zl, 32'h3);
        alu1(4'd4, 32'h8000_0001, 32'd33); read_z(zh, zl); check("shr_33", zl, 32'h4000_0000);

        // MUL latency and result
        start_md(4'd10, 32'hFFFF_FFFF, 32'd2);
        wait_done(bc);
        check("mul_busy_cycles", bc, 32);
        read_z(zh, zl);
        check("mul_hi", zh, 32'h1);
        check("mul_lo", zl, 32'hFFFF_FFFE);

        // Non MUL/DIV start is ignored
        alu_op = 4'd0; alu_start = 1; tick(); idle();
        check("plain_start_ignored", alu_busy, 1'b0);

        // DIV with z_in and a second start injected while busy
        start_md(4'd11, 32'd100, 32'd7);
        tick(3);
        z_in = 1; alu_op = 4'd0; tick(); idle();
        alu_op = 4'd11; alu_start = 1; tick(); idle();
        wait_done(bc);
        check("div_busy_left", bc, 27);
        read_z(zh, zl);
        check("div_rem", zh, 32'd2);
        check("div_quo", zl, 32'd14);

        start_md(4'd11, 32'd5, 32'd0);
        wait_done(bc);
        read_z(zh, zl);
        check("div0_rem", zh, 32'd5);
        check("div0_quo", zl, 32'hFFFF_FFFF);

        // Start coinciding with completion is dropped
        start_md(4'd10, 32'd3, 32'd4);
        tick(31);
        mdr_out = 1; alu_op = 4'd10; alu_start = 1; tick(); idle();
        check("race_done", alu_done, 1'b1);
        check("race_busy", alu_busy, 1'b0);
        read_z(zh, zl);
        check("race_z_lo", zl, 32'd12);

        // Bus contention
        load_gpr(1, 32'hA5);
        gpr_out[1] = 1; pc_out = 1;
        #1 check("contend_bus", bus_data, 32'h0);
        tick(); idle();
        check("err_set", bus_err, 1'b1);
        tick(10);
        check("err_sticky", bus_err, 1'b1);

        // Reset aborts a MUL mid-flight
        start_md(4'd10, 32'hFFFF_FFFF, 32'd2);
        tick(16);
        z_low_out = 1;
        #1 reset_n = 0;
        #1;
        check("abort_busy", alu_busy, 1'b0);
        check("abort_z", bus_data, 32'h0);
        check("abort_err", bus_err, 1'b0);
        idle();
        tick(2);
        reset_n = 1; alu_op = 4'd10; alu_start = 1; tick(); idle();
        check("start_after_rst", alu_busy, 1'b1);
        wait_done(bc);
        start_md(4'd10, 32'd123456, 32'd789);
        wait_done(bc);
        read_z(zh, zl);
        check("mul2_hi", zh, 32'd0);
        check("mul2_lo", zl, 32'd97406784);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
